// File: rtl/prf_free_list_pkg.sv
// Shared sizing defaults, tag type and pointer-wrap helper for the physical-tag free list.
package prf_free_list_pkg;

    localparam int unsigned NUM_AREG_DEF = 8;
    localparam int unsigned NUM_PREG_DEF = 32;
    localparam int unsigned TAG_W        = $clog2(NUM_PREG_DEF);

    typedef logic [TAG_W-1:0] ptag_t;

    // Compare-and-subtract wrap; valid while n <= depth, so depth need not be a power of 2.
    function automatic int unsigned wrap_inc(int unsigned ptr, int unsigned n,
                                             int unsigned depth);
        int unsigned s;
        s = ptr + n;
        if (s >= depth) begin
            s = s - depth;
        end
        return s;
    endfunction

endpackage

// File: rtl/prf_free_list_dbl_chk.sv
// Double-free checker for prf_free_list: free bitmap plus sticky err flag.
// Only compiled and used when FREE_LIST_CHECK_EN is defined.
`ifdef FREE_LIST_CHECK_EN
module prf_free_list_dbl_chk #(
    parameter int unsigned NUM_AREG = 8,
    parameter int unsigned NUM_PREG = 32,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned TW       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WAYS-1:0]    clr_vld,
    input  logic [WAYS*TW-1:0] clr_tag,
    input  logic [WAYS-1:0]    set_vld,
    input  logic [WAYS*TW-1:0] set_tag,
    output logic               err
);
    logic [NUM_PREG-1:0] map_q, map_d;
    logic                err_q, err_d;

    // A bit is set while its tag is not architecturally mapped (free or only speculatively held),
    // so flush never needs to touch the bitmap.
    always_comb begin
        map_d = map_q;
        err_d = err_q;
        for (int i = 0; i < int'(WAYS); i++) begin
            if (clr_vld[i] && (32'(clr_tag[i*TW +: TW]) < NUM_PREG)) begin
                map_d[clr_tag[i*TW +: TW]] = 1'b0;
            end
        end
        for (int i = 0; i < int'(WAYS); i++) begin
            if (set_vld[i]) begin
                if (32'(set_tag[i*TW +: TW]) >= NUM_PREG) begin
                    err_d = 1'b1;
                end else begin
                    if (map_q[set_tag[i*TW +: TW]]) begin
                        err_d = 1'b1;
                    end
                    map_d[set_tag[i*TW +: TW]] = 1'b1;
                end
                for (int j = 0; j < i; j++) begin
                    if (set_vld[j] && (set_tag[j*TW +: TW] == set_tag[i*TW +: TW])) begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q <= {NUM_PREG{1'b1}} << NUM_AREG;
            err_q <= 1'b0;
        end else begin
            map_q <= map_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule
`endif

// File: rtl/prf_free_list.sv
// Physical-tag free list: packed multi-lane alloc, commit-side release, flush to arch head.
// Define FREE_LIST_CHECK_EN to add the double-free checker (err output); otherwise err is 0.
module prf_free_list
    import prf_free_list_pkg::*;
#(
    parameter int unsigned NUM_AREG = NUM_AREG_DEF,
    parameter int unsigned NUM_PREG = NUM_PREG_DEF,
    parameter int unsigned WAYS     = 2,
    localparam int unsigned TW      = $clog2(NUM_PREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WAYS-1:0]    alloc_req,
    output logic               alloc_ok,
    output logic [WAYS*TW-1:0] alloc_tag,
    input  logic [WAYS-1:0]    cmt_alloc,
    input  logic [WAYS-1:0]    cmt_free_vld,
    input  logic [WAYS*TW-1:0] cmt_free_tag,
    input  logic               flush,
    output logic [TW:0]        free_cnt,
    output logic               empty,
    output logic               err
);
    localparam int unsigned DEPTH = NUM_PREG - NUM_AREG;
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [TW:0]   cnt_t;

    function automatic ptr_t inc(ptr_t p, int unsigned n);
        return ptr_t'(wrap_inc(32'(p), n, DEPTH));
    endfunction

    logic [TW-1:0] fl_q [DEPTH];
    logic [TW-1:0] fl_d [DEPTH];
    ptr_t          head_q, head_d, tail_q, tail_d, arch_head_q, arch_head_d;
    cnt_t          count_q, count_d, arch_count_q, arch_count_d;
    int unsigned   n_req, n_rel, n_cmt;
    logic          grant;

    // Grant decision uses the registered count only: no release-to-alloc bypass.
    always_comb begin
        n_req = $countones(alloc_req);
        n_rel = $countones(cmt_free_vld);
        n_cmt = $countones(cmt_alloc);
        grant = !flush && (count_q >= cnt_t'(n_req));
    end

    always_comb begin
        int unsigned off;
        off       = 0;
        alloc_tag = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            alloc_tag[i*TW +: TW] = fl_q[inc(head_q, off)];
            if (alloc_req[i]) begin
                off = off + 1;
            end
        end
    end

    always_comb begin
        int unsigned off;
        off  = 0;
        fl_d = fl_q;
        for (int i = 0; i < int'(WAYS); i++) begin
            if (cmt_free_vld[i]) begin
                fl_d[inc(tail_q, off)] = cmt_free_tag[i*TW +: TW];
                off = off + 1;
            end
        end
        tail_d       = inc(tail_q, n_rel);
        arch_head_d  = inc(arch_head_q, n_cmt);
        arch_count_d = arch_count_q + cnt_t'(n_rel) - cnt_t'(n_cmt);
        head_d       = grant ? inc(head_q, n_req) : head_q;
        count_d      = count_q - (grant ? cnt_t'(n_req) : cnt_t'(0)) + cnt_t'(n_rel);
        // Flush rolls the speculative view back onto the post-commit architectural view.
        if (flush) begin
            head_d  = arch_head_d;
            count_d = arch_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fl_q[i] <= TW'(NUM_AREG + 32'(i));
            end
            head_q       <= '0;
            tail_q       <= '0;
            arch_head_q  <= '0;
            count_q      <= cnt_t'(DEPTH);
            arch_count_q <= cnt_t'(DEPTH);
        end else begin
            fl_q         <= fl_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            arch_head_q  <= arch_head_d;
            count_q      <= count_d;
            arch_count_q <= arch_count_d;
        end
    end

    assign alloc_ok = grant;
    assign free_cnt = count_q;
    assign empty    = (count_q == '0);

`ifdef FREE_LIST_CHECK_EN
    logic [WAYS*TW-1:0] cmt_tag;

    // Tags leaving the list architecturally are those at arch_head in commit-lane order.
    always_comb begin
        int unsigned off;
        off     = 0;
        cmt_tag = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            cmt_tag[i*TW +: TW] = fl_q[inc(arch_head_q, off)];
            if (cmt_alloc[i]) begin
                off = off + 1;
            end
        end
    end

    prf_free_list_dbl_chk #(
        .NUM_AREG (NUM_AREG),
        .NUM_PREG (NUM_PREG),
        .WAYS     (WAYS),
        .TW       (TW)
    ) u_dbl_chk (
        .clk     (clk),
        .rst     (rst),
        .clr_vld (cmt_alloc),
        .clr_tag (cmt_tag),
        .set_vld (cmt_free_vld),
        .set_tag (cmt_free_tag),
        .err     (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list: directed scenarios plus randomized traffic vs a queue model.
module tb_prf_free_list;
    import prf_free_list_pkg::*;

    localparam int DEPTH = 24;
`ifdef FREE_LIST_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alloc_req;
    logic        alloc_ok;
    logic [9:0]  alloc_tag;
    logic [1:0]  cmt_alloc;
    logic [1:0]  cmt_free_vld;
    logic [9:0]  cmt_free_tag;
    logic        flush;
    logic [5:0]  free_cnt;
    logic        empty;
    logic        err;

    always #5 clk = ~clk;

    prf_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_ok     (alloc_ok),
        .alloc_tag    (alloc_tag),
        .cmt_alloc    (cmt_alloc),
        .cmt_free_vld (cmt_free_vld),
        .cmt_free_tag (cmt_free_tag),
        .flush        (flush),
        .free_cnt     (free_cnt),
        .empty        (empty),
        .err          (err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Model: free tags in allocation order, speculatively held tags, architecturally mapped tags.
    int   free_q[$];
    int   spec_q[$];
    int   used_q[$];
    logic err_m;

    logic       obs_ok, obs_empty, obs_err;
    ptag_t      obs_tag[2];
    logic [5:0] obs_cnt;
    logic       exp_ok, exp_empty, exp_err;
    ptag_t      exp_tag[2];
    logic [5:0] exp_cnt;

    function automatic logic in_q(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        used_q.delete();
        for (int i = 0; i < DEPTH; i++) free_q.push_back(8 + i);
        for (int i = 0; i < 8; i++) used_q.push_back(i);
        err_m = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; alloc_req = '0; cmt_alloc = '0; cmt_free_vld = '0;
        cmt_free_tag = '0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one cycle, capture outputs before the edge, predict them, then advance the model.
    task automatic cycle(input logic [1:0] req, input logic [1:0] cmt, input logic [1:0] fv,
                         input int t0, input int t1, input logic fl);
        int k;
        int tg[2];
        @(negedge clk);
        alloc_req = req; cmt_alloc = cmt; cmt_free_vld = fv;
        cmt_free_tag = {5'(t1), 5'(t0)}; flush = fl;
        #1;
        obs_ok = alloc_ok; obs_tag[0] = alloc_tag[4:0]; obs_tag[1] = alloc_tag[9:5];
        obs_cnt = free_cnt; obs_empty = empty; obs_err = err;
        exp_ok = !fl && (free_q.size() >= $countones(req));
        k = 0;
        for (int i = 0; i < 2; i++) begin
            exp_tag[i] = '0;
            if (req[i]) begin
                if (exp_ok) exp_tag[i] = ptag_t'(free_q[k]);
                k++;
            end
        end
        exp_cnt = 6'(free_q.size());
        exp_empty = (free_q.size() == 0);
        exp_err = err_m;
        tg[0] = t0; tg[1] = t1;
        if (CHK) begin
            for (int i = 0; i < 2; i++)
                if (fv[i] && (in_q(free_q, tg[i]) || in_q(spec_q, tg[i]) || tg[i] >= 32))
                    err_m = 1'b1;
            if (fv == 2'b11 && t0 == t1) err_m = 1'b1;
        end
        @(posedge clk);
        if (exp_ok) for (int i = 0; i < 2; i++) if (req[i]) spec_q.push_back(free_q.pop_front());
        for (int i = 0; i < 2; i++) if (cmt[i]) used_q.push_back(spec_q.pop_front());
        for (int i = 0; i < 2; i++) if (fv[i]) free_q.push_back(tg[i]);
        if (fl) begin
            for (int i = spec_q.size() - 1; i >= 0; i--) free_q.push_front(spec_q[i]);
            spec_q.delete();
        end
    endtask

    task automatic alloc(input logic [1:0] req);
        cycle(req, 2'b00, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        alloc(2'b11);
        alloc(2'b11);
        // Reset with busy inputs must still land in the reset state.
        @(negedge clk);
        rst = 1'b1; alloc_req = 2'b11; cmt_free_vld = 2'b11; cmt_free_tag = {5'd2, 5'd1};
        flush = 1'b1; cmt_alloc = 2'b11;
        @(negedge clk);
        rst = 1'b0; alloc_req = '0; cmt_free_vld = '0; cmt_alloc = '0; flush = 1'b0;
        model_reset();
        alloc(2'b00);
        n_cmp++;
        if (obs_cnt !== 6'd24) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 24", obs_cnt);
        end
        n_cmp++;
        if (obs_empty !== 1'b0) begin
            n_fail++; $display("FAIL reset_empty: got %b want 0", obs_empty);
        end
        n_cmp++;
        if (obs_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", obs_err);
        end
    endtask

    task automatic test_alloc_pair();
        do_reset();
        alloc(2'b11);
        n_cmp++;
        if (obs_ok !== 1'b1 || obs_tag[0] !== 5'd8 || obs_tag[1] !== 5'd9) begin
            n_fail++;
            $display("FAIL pair_grant: ok=%b tags=%0d,%0d want ok=1 tags=8,9",
                     obs_ok, obs_tag[0], obs_tag[1]);
        end
        alloc(2'b00);
        n_cmp++;
        if (obs_cnt !== 6'd22) begin
            n_fail++; $display("FAIL pair_cnt: got %0d want 22", obs_cnt);
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            alloc(2'b11);
            n_cmp++;
            if (obs_ok !== 1'b1 || obs_tag[0] !== exp_tag[0] || obs_tag[1] !== exp_tag[1]) begin
                n_fail++;
                $display("FAIL exhaust_grant c%0d: ok=%b tags=%0d,%0d want ok=1 tags=%0d,%0d",
                         c, obs_ok, obs_tag[0], obs_tag[1], exp_tag[0], exp_tag[1]);
            end
        end
        alloc(2'b00);
        n_cmp++;
        if (obs_cnt !== 6'd0 || obs_empty !== 1'b1) begin
            n_fail++; $display("FAIL exhaust_empty: cnt=%0d empty=%b want 0/1", obs_cnt, obs_empty);
        end
        alloc(2'b01);
        n_cmp++;
        if (obs_ok !== 1'b0) begin
            n_fail++; $display("FAIL exhaust_refuse: ok=%b want 0", obs_ok);
        end
        alloc(2'b00);
        n_cmp++;
        if (obs_cnt !== 6'd0) begin
            n_fail++; $display("FAIL exhaust_hold: cnt=%0d want 0", obs_cnt);
        end
    endtask

    task automatic test_partial();
        do_reset();
        for (int c = 0; c < 11; c++) alloc(2'b11);
        alloc(2'b01);
        alloc(2'b11);
        n_cmp++;
        if (obs_cnt !== 6'd1 || obs_ok !== 1'b0) begin
            n_fail++; $display("FAIL partial_refuse: cnt=%0d ok=%b want 1/0", obs_cnt, obs_ok);
        end
        alloc(2'b10);
        n_cmp++;
        if (obs_ok !== 1'b1 || obs_tag[1] !== 5'd31 || obs_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL partial_lane1: ok=%b tag=%0d cnt=%0d want 1/31/1",
                     obs_ok, obs_tag[1], obs_cnt);
        end
        alloc(2'b00);
        n_cmp++;
        if (obs_cnt !== 6'd0) begin
            n_fail++; $display("FAIL partial_cnt: got %0d want 0", obs_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        alloc(2'b11);
        alloc(2'b11);
        cycle(2'b11, 2'b11, 2'b00, 0, 0, 1'b1);
        n_cmp++;
        if (obs_ok !== 1'b0) begin
            n_fail++; $display("FAIL flush_ok: got %b want 0", obs_ok);
        end
        alloc(2'b11);
        n_cmp++;
        if (obs_cnt !== 6'd22 || obs_tag[0] !== 5'd10 || obs_tag[1] !== 5'd11) begin
            n_fail++;
            $display("FAIL flush_restore: cnt=%0d tags=%0d,%0d want 22 tags=10,11",
                     obs_cnt, obs_tag[0], obs_tag[1]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 12; c++) alloc(2'b11);
        for (int c = 0; c < 12; c++) cycle(2'b00, 2'b11, 2'b00, 0, 0, 1'b0);
        for (int c = 0; c < 11; c++) cycle(2'b00, 2'b00, 2'b11, 8 + 2*c, 9 + 2*c, 1'b0);
        cycle(2'b00, 2'b00, 2'b01, 30, 0, 1'b0);
        alloc(2'b11);
        n_cmp++;
        if (obs_cnt !== 6'd23 || obs_tag[0] !== 5'd8 || obs_tag[1] !== 5'd9) begin
            n_fail++;
            $display("FAIL wrap_refill: cnt=%0d tags=%0d,%0d want 23 tags=8,9",
                     obs_cnt, obs_tag[0], obs_tag[1]);
        end
        cycle(2'b11, 2'b00, 2'b11, 3, 4, 1'b0);
        alloc(2'b00);
        n_cmp++;
        if (obs_cnt !== 6'd21) begin
            n_fail++; $display("FAIL wrap_rel_alloc: cnt=%0d want 21", obs_cnt);
        end
        for (int c = 0; c < 9; c++) alloc(2'b11);
        alloc(2'b01);
        alloc(2'b11);
        n_cmp++;
        if (obs_ok !== 1'b1 || obs_tag[0] !== 5'd3 || obs_tag[1] !== 5'd4) begin
            n_fail++;
            $display("FAIL wrap_tags: ok=%b tags=%0d,%0d want 1 tags=3,4",
                     obs_ok, obs_tag[0], obs_tag[1]);
        end
    endtask

    task automatic test_dbl_free();
        do_reset();
        cycle(2'b00, 2'b00, 2'b01, 8, 0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            alloc(2'b00);
            n_cmp++;
            if (obs_err !== CHK) begin
                n_fail++; $display("FAIL dbl_free_err c%0d: got %b want %b", c, obs_err, CHK);
            end
        end
        do_reset();
        alloc(2'b00);
        n_cmp++;
        if (obs_err !== 1'b0) begin
            n_fail++; $display("FAIL dbl_free_clear: got %b want 0", obs_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [1:0] req, cmt, fv;
            int         t[2];
            int         idx;
            logic       fl;
            req = 2'($urandom_range(0, 3));
            cmt = 2'($urandom_range(0, 3));
            if (spec_q.size() == 0) cmt = 2'b00;
            else if (spec_q.size() == 1 && cmt == 2'b11) cmt = 2'b10;
            fv = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            if (used_q.size() == 0) fv = 2'b00;
            else if (used_q.size() == 1 && fv == 2'b11) fv = 2'b01;
            t[0] = 0; t[1] = 0;
            for (int i = 0; i < 2; i++) begin
                if (fv[i]) begin
                    idx = int'($urandom_range(0, used_q.size() - 1));
                    t[i] = used_q[idx];
                    used_q.delete(idx);
                end
            end
            fl = ($urandom_range(0, 15) == 0);
            cycle(req, cmt, fv, t[0], t[1], fl);
            n_cmp++;
            if (obs_ok !== exp_ok || obs_cnt !== exp_cnt || obs_empty !== exp_empty ||
                obs_err !== exp_err) begin
                n_fail++;
                $display("FAIL rand_state c%0d: ok=%b cnt=%0d empty=%b err=%b want %b/%0d/%b/%b",
                         c, obs_ok, obs_cnt, obs_empty, obs_err,
                         exp_ok, exp_cnt, exp_empty, exp_err);
            end
            for (int i = 0; i < 2; i++) begin
                if (req[i] && exp_ok) begin
                    n_cmp++;
                    if (obs_tag[i] !== exp_tag[i]) begin
                        n_fail++;
                        $display("FAIL rand_tag c%0d lane%0d: got %0d want %0d",
                                 c, i, obs_tag[i], exp_tag[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; alloc_req = '0; cmt_alloc = '0; cmt_free_vld = '0;
        cmt_free_tag = '0; flush = 1'b0;
        model_reset();
        test_reset();
        test_alloc_pair();
        test_exhaust();
        test_partial();
        test_flush();
        test_wrap();
        test_dbl_free();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
